mem_sys_initiator: RTL and testbench

- System-side master for the memory controller's command interface. It drives cmd_valid_sys, we_sys, addr_sys and data_sys, waits for ready_sys, and returns read data.
- A local request FIFO decouples the producer (bench driver or upstream logic) from the controller handshake.
- It replaces the bench program as the active end of the controller's system port, so the same handshake can be exercised in RTL.

---
 rtl/mem_sys_pkg.sv | 19 +
 rtl/mem_req_fifo.sv | 56 +++++
 rtl/mem_sys_initiator.sv | 157 +++++++++++++++
 tb/tb_mem_sys_initiator.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_sys_pkg.sv
// Shared types for the memory-system initiator: request payload and FSM states.
package mem_sys_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 8;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } init_state_e;

endpackage

// File: rtl/mem_req_fifo.sv
// Request FIFO between the producer and the initiator FSM.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module mem_req_fifo
    import mem_sys_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     push,
    input  mem_req_t push_data,
    input  logic     pop,
    output mem_req_t pop_data,
    output logic     full,
    output logic     empty
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    mem_req_t         mem_q [DEPTH];
    mem_req_t         mem_d [DEPTH];

    assign full     = (wptr_q[IDX_W] != rptr_q[IDX_W]) &&
                      (wptr_q[IDX_W-1:0] == rptr_q[IDX_W-1:0]);
    assign empty    = (wptr_q == rptr_q);
    assign pop_data = mem_q[rptr_q[IDX_W-1:0]];

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push && !full) begin
            mem_d[wptr_q[IDX_W-1:0]] = push_data;
            wptr_d = wptr_q + PTR_W'(1);
        end
        if (pop && !empty) begin
            rptr_d = rptr_q + PTR_W'(1);
        end
    end

    // Storage needs no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
        mem_q <= mem_d;
    end

endmodule

// File: rtl/mem_sys_initiator.sv
// System-side master for the memory controller command port: queues requests,
// issues them one at a time with a one-cycle gap, and reports completion or timeout.
module mem_sys_initiator
    import mem_sys_pkg::*;
#(
    parameter int unsigned REQ_DEPTH      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic              rsp_we,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              cmd_valid_sys,
    output logic              we_sys,
    output logic [ADDR_W-1:0] addr_sys,
    output logic [DATA_W-1:0] data_sys_out,
    output logic              data_sys_oe,
    input  logic [DATA_W-1:0] data_sys_in,
    input  logic              ready_sys,
    output logic              busy
);

    localparam int unsigned CNT_W = 8;

    init_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              oe_q, oe_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_we_q, rsp_we_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic              fifo_full, fifo_empty, pop_c;
    mem_req_t          push_req, head_req;

    assign push_req = '{we: req_we, addr: req_addr, wdata: req_wdata};

    mem_req_fifo #(.DEPTH(REQ_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (req_valid && !fifo_full),
        .push_data (push_req),
        .pop       (pop_c),
        .pop_data  (head_req),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_valid_d = cmd_valid_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        oe_d        = oe_q;
        rsp_valid_d = 1'b0;
        rsp_we_d    = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        pop_c       = 1'b0;

        case (state_q)
            IDLE, GAP: begin
                cmd_valid_d = 1'b0;
                oe_d        = 1'b0;
                cnt_d       = '0;
                state_d     = IDLE;
                if (!fifo_empty) begin
                    pop_c       = 1'b1;
                    cmd_valid_d = 1'b1;
                    we_d        = head_req.we;
                    addr_d      = head_req.addr;
                    wdata_d     = head_req.wdata;
                    oe_d        = head_req.we;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d = cnt_q + CNT_W'(1);
                // ready_sys takes priority over a coincident timeout.
                if (ready_sys) begin
                    rsp_valid_d = 1'b1;
                    rsp_we_d    = we_q;
                    rsp_rdata_d = we_q ? '0 : data_sys_in;
                    cmd_valid_d = 1'b0;
                    oe_d        = 1'b0;
                    state_d     = GAP;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    rsp_valid_d = 1'b1;
                    rsp_we_d    = we_q;
                    rsp_err_d   = 1'b1;
                    cmd_valid_d = 1'b0;
                    oe_d        = 1'b0;
                    state_d     = GAP;
                end
            end
            default: begin
                cmd_valid_d = 1'b0;
                oe_d        = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cmd_valid_q <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            oe_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_we_q    <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_valid_q <= cmd_valid_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            oe_q        <= oe_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_we_q    <= rsp_we_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready     = !fifo_full;
    assign busy          = (state_q != IDLE) || !fifo_empty;
    assign cmd_valid_sys = cmd_valid_q;
    assign we_sys        = we_q;
    assign addr_sys      = addr_q;
    assign data_sys_out  = wdata_q;
    assign data_sys_oe   = oe_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_we        = rsp_we_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_err       = rsp_err_q;

endmodule

// File: tb/tb_mem_sys_initiator.sv
// Directed bench for mem_sys_initiator; the bench plays the controller side by hand.
module tb_mem_sys_initiator;

    logic       clk;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic       req_we;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic       rsp_we;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       cmd_valid_sys;
    logic       we_sys;
    logic [7:0] addr_sys;
    logic [7:0] data_sys_out;
    logic       data_sys_oe;
    logic [7:0] data_sys_in;
    logic       ready_sys;
    logic       busy;

    int checks = 0;
    int errors = 0;

    mem_sys_initiator dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_we        (rsp_we),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .cmd_valid_sys (cmd_valid_sys),
        .we_sys        (we_sys),
        .addr_sys      (addr_sys),
        .data_sys_out  (data_sys_out),
        .data_sys_oe   (data_sys_oe),
        .data_sys_in   (data_sys_in),
        .ready_sys     (ready_sys),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_cmd_valid"}, cmd_valid_sys, 1'b0);
        chk({tag, "_oe"},        data_sys_oe,   1'b0);
        chk({tag, "_rsp_valid"}, rsp_valid,     1'b0);
        chk({tag, "_busy"},      busy,          1'b0);
        chk({tag, "_req_ready"}, req_ready,     1'b1);
    endtask

    // Waits (bounded) for req_ready, then pushes for exactly one edge.
    task automatic push(input logic we, input logic [7:0] a, input logic [7:0] d);
        int n;
        n = 0;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        chk("push_ready", req_ready, 1'b1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        req_valid   = 1'b0;
        req_we      = 1'b0;
        req_addr    = '0;
        req_wdata   = '0;
        data_sys_in = '0;
        ready_sys   = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        chk_quiet("reset");
        chk("reset_we",    we_sys,       1'b0);
        chk("reset_addr",  addr_sys,     8'h00);
        chk("reset_data",  data_sys_out, 8'h00);
        chk("reset_rsp_we",  rsp_we,     1'b0);
        chk("reset_rdata", rsp_rdata,    8'h00);
        chk("reset_err",   rsp_err,      1'b0);

        // Single write, controller ready in the third ISSUE cycle
        push(1'b1, 8'h10, 8'hA5);
        chk("w1_cv_t0", cmd_valid_sys, 1'b0);
        chk("w1_busy",  busy,          1'b1);
        tick();
        chk("w1_cv_c1",   cmd_valid_sys, 1'b1);
        chk("w1_we",      we_sys,        1'b1);
        chk("w1_addr",    addr_sys,      8'h10);
        chk("w1_data",    data_sys_out,  8'hA5);
        chk("w1_oe_c1",   data_sys_oe,   1'b1);
        tick();
        chk("w1_cv_c2",   cmd_valid_sys, 1'b1);
        chk("w1_oe_c2",   data_sys_oe,   1'b1);
        chk("w1_rv_c2",   rsp_valid,     1'b0);
        ready_sys = 1'b1;
        tick();
        ready_sys = 1'b0;
        chk("w1_cv_done", cmd_valid_sys, 1'b0);
        chk("w1_oe_done", data_sys_oe,   1'b0);
        chk("w1_rsp_v",   rsp_valid,     1'b1);
        chk("w1_rsp_we",  rsp_we,        1'b1);
        chk("w1_rsp_err", rsp_err,       1'b0);
        chk("w1_rsp_rd",  rsp_rdata,     8'h00);
        tick();
        chk_quiet("w1_end");

        // ready_sys while idle must be ignored
        ready_sys = 1'b1;
        tick();
        tick();
        ready_sys = 1'b0;
        chk_quiet("idle_ready");

        // Write then read back with one idle cycle between commands
        push(1'b1, 8'h20, 8'h3C);
        push(1'b0, 8'h20, 8'h00);
        chk("wr_cv",   cmd_valid_sys, 1'b1);
        chk("wr_we",   we_sys,        1'b1);
        chk("wr_oe",   data_sys_oe,   1'b1);
        ready_sys = 1'b1;
        tick();
        ready_sys = 1'b0;
        chk("wr_rsp_v",  rsp_valid,     1'b1);
        chk("wr_rsp_we", rsp_we,        1'b1);
        chk("wr_gap_cv", cmd_valid_sys, 1'b0);
        chk("wr_gap_oe", data_sys_oe,   1'b0);
        data_sys_in = 8'h3C;
        tick();
        chk("rd_cv",     cmd_valid_sys, 1'b1);
        chk("rd_we",     we_sys,        1'b0);
        chk("rd_oe",     data_sys_oe,   1'b0);
        chk("rd_addr",   addr_sys,      8'h20);
        chk("rd_rsp_v0", rsp_valid,     1'b0);
        ready_sys = 1'b1;
        tick();
        ready_sys = 1'b0;
        chk("rd_rsp_v",   rsp_valid, 1'b1);
        chk("rd_rsp_we",  rsp_we,    1'b0);
        chk("rd_rsp_rd",  rsp_rdata, 8'h3C);
        chk("rd_rsp_err", rsp_err,   1'b0);
        tick();
        chk_quiet("rd_end");

        // FIFO full with the controller stalled; completion order must match pushes
        for (int i = 0; i < 5; i++) begin
            push(1'b0, 8'(8'h40 + i), 8'h00);
            if (i == 3) chk("full_after4", req_ready, 1'b1);
        end
        chk("full_after5", req_ready,     1'b0);
        chk("full_busy",   busy,          1'b1);
        chk("full_cv",     cmd_valid_sys, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("ord_cv",   cmd_valid_sys, 1'b1);
            chk("ord_addr", addr_sys,      8'(8'h40 + i));
            data_sys_in = 8'(8'hC0 + i);
            ready_sys   = 1'b1;
            tick();
            ready_sys = 1'b0;
            chk("ord_rsp_v",  rsp_valid, 1'b1);
            chk("ord_rsp_rd", rsp_rdata, 8'(8'hC0 + i));
            if (i == 0) chk("ord_still_full", req_ready, 1'b0);
            tick();
            if (i == 0) chk("ord_reopen", req_ready, 1'b1);
        end
        chk_quiet("ord_end");

        // Timeout: 16 ISSUE cycles without ready, then the queued write issues after one gap
        push(1'b0, 8'h50, 8'h00);
        push(1'b1, 8'h51, 8'h77);
        data_sys_in = 8'hEE;
        chk("to_cv_c1", cmd_valid_sys, 1'b1);
        chk("to_addr",  addr_sys,      8'h50);
        repeat (15) tick();
        chk("to_cv_c16", cmd_valid_sys, 1'b1);
        chk("to_rv_c16", rsp_valid,     1'b0);
        tick();
        chk("to_rsp_v",   rsp_valid,     1'b1);
        chk("to_rsp_err", rsp_err,       1'b1);
        chk("to_rsp_rd",  rsp_rdata,     8'h00);
        chk("to_rsp_we",  rsp_we,        1'b0);
        chk("to_gap_cv",  cmd_valid_sys, 1'b0);
        tick();
        chk("to_next_cv",   cmd_valid_sys, 1'b1);
        chk("to_next_addr", addr_sys,      8'h51);
        chk("to_next_oe",   data_sys_oe,   1'b1);
        chk("to_next_rv",   rsp_valid,     1'b0);
        ready_sys = 1'b1;
        tick();
        ready_sys = 1'b0;
        chk("to_next_rsp_v",   rsp_valid, 1'b1);
        chk("to_next_rsp_err", rsp_err,   1'b0);
        chk("to_next_rsp_we",  rsp_we,    1'b1);
        tick();
        chk_quiet("to_end");

        // ready_sys in the 16th ISSUE cycle beats the timeout
        push(1'b0, 8'h60, 8'h00);
        tick();
        data_sys_in = 8'h5A;
        chk("rt_cv_c1", cmd_valid_sys, 1'b1);
        repeat (15) tick();
        chk("rt_cv_c16", cmd_valid_sys, 1'b1);
        ready_sys = 1'b1;
        tick();
        ready_sys = 1'b0;
        chk("rt_rsp_v",   rsp_valid, 1'b1);
        chk("rt_rsp_err", rsp_err,   1'b0);
        chk("rt_rsp_rd",  rsp_rdata, 8'h5A);
        tick();
        chk_quiet("rt_end");

        // Reset mid-ISSUE with two requests still queued
        push(1'b1, 8'h70, 8'h11);
        push(1'b1, 8'h71, 8'h22);
        push(1'b0, 8'h72, 8'h00);
        chk("rst_cv_pre",   cmd_valid_sys, 1'b1);
        chk("rst_busy_pre", busy,          1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_quiet("rst_now");
        chk("rst_we",   we_sys,   1'b0);
        chk("rst_addr", addr_sys, 8'h00);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_quiet("rst_after");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
